rv32i_fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end placed between the instruction memory and RV32I_core in the next-generation top.
- Replaces the combinational PC-to-instruction path with a request/response memory interface that tolerates variable latency and wait states.
- Fetched words go into a prefetch FIFO. The core consumes them through a valid/ready handshake.
- Supports PC redirect (branch/jump) with a FIFO flush and discard of any in-flight response.

---
 rtl/rv32i_fetch_unit.sv | 192 +++++++++++++++++++
 tb/tb_rv32i_fetch_unit.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_fetch_unit.sv
// rv32i_fetch_unit
// Instruction fetch front end between the instruction memory and the core.
// It issues word requests on a request/grant memory port with at most one
// request outstanding. It buffers returned words with their PCs in a prefetch
// FIFO and presents the FIFO head to the core over a valid/ready handshake.
// A redirect flushes the FIFO and discards any response still in flight.
//
// Handshakes:
//   imem_req/imem_gnt   : a request is accepted in a cycle with req && gnt;
//                         while req=1 and gnt=0, imem_addr is held stable.
//   imem_rvalid         : the single outstanding response, at least one cycle
//                         after its grant.
//   instr_valid/ready   : the head is consumed in a cycle with valid && ready;
//                         the head data and PC are stable while valid && !ready.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   fetch_en            allows new requests to be issued
//   redirect_valid/pc   one-cycle restart of the fetch stream at redirect_pc
//   imem_req/addr       memory request and word address
//   imem_gnt            memory accepts the request this cycle
//   imem_rvalid/rdata   memory response
//   instr_valid/ready   FIFO head handshake towards the core
//   instr_data/pc       instruction word and PC at the FIFO head
//   dbg_state_o         current fetch FSM state (IDLE=0, REQ=1, WAIT=2, WAIT_DROP=3)
module rv32i_fetch_unit #(
   parameter int unsigned     XLEN       = 32,
   parameter int unsigned     FIFO_DEPTH = 4,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int unsigned     PC_STEP    = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            fetch_en,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] instr_data,
   output logic [XLEN-1:0] instr_pc,
   output logic [1:0]      dbg_state_o
);

   localparam int unsigned       PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned       CNT_W      = PTR_W + 1;
   localparam logic [CNT_W:0]    DEPTH_OCC  = (CNT_W+1)'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]  DEPTH_CNT  = CNT_W'(FIFO_DEPTH);
   localparam logic [XLEN-1:0]   STEP       = XLEN'(PC_STEP);
   localparam logic [XLEN-1:0]   ALIGN_MASK = ~(XLEN'(3));

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_REQ       = 2'd1,
      S_WAIT      = 2'd2,
      S_WAIT_DROP = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]   req_pc_q, req_pc_d;
   logic [XLEN-1:0]   mem_data_q [FIFO_DEPTH];
   logic [XLEN-1:0]   mem_pc_q   [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic              outstanding;
   logic              drop;
   logic              resp;
   logic [CNT_W:0]    occ;
   logic              credit;
   logic              issue_resp;
   logic              accept;
   logic              push;
   logic              pop;
   logic              full;

   // Occupancy counts the FIFO, a still-pending response, and a response
   // being pushed this cycle. A pop in this cycle is deliberately not credited.
   always_comb begin
      outstanding = (state_q == S_WAIT) || (state_q == S_WAIT_DROP);
      drop        = (state_q == S_WAIT_DROP);
      resp        = outstanding && imem_rvalid;
      occ         = {1'b0, count_q}
                  + {{CNT_W{1'b0}}, outstanding && !imem_rvalid}
                  + {{CNT_W{1'b0}}, resp && !drop};
      credit      = fetch_en && (occ < DEPTH_OCC);
      // The next request goes out in the same cycle that the current response
      // returns. This keeps one word per cycle with a single outstanding request.
      issue_resp  = resp && credit && !redirect_valid;
      accept      = imem_req && imem_gnt;
      push        = resp && !drop && !redirect_valid;
      pop         = instr_valid && instr_ready && !redirect_valid;
      full        = (count_q == DEPTH_CNT);
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // FIFO storage. Every read is gated by instr_valid, so the storage needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data_q[wr_ptr_q] <= imem_rdata;
         mem_pc_q[wr_ptr_q]   <= req_pc_q;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            // After a redirect the FIFO is empty, so only fetch_en gates issue.
            if (redirect_valid) state_d = fetch_en ? S_REQ : S_IDLE;
            else if (credit)    state_d = S_REQ;
         end
         S_REQ: begin
            // A grant that coincides with a redirect fetched a stale PC.
            if (imem_gnt) state_d = redirect_valid ? S_WAIT_DROP : S_WAIT;
         end
         S_WAIT, S_WAIT_DROP: begin
            if (imem_rvalid) begin
               if (redirect_valid) state_d = fetch_en ? S_REQ : S_IDLE;
               else if (credit)    state_d = imem_gnt ? S_WAIT : S_REQ;
               else                state_d = S_IDLE;
            end else if (redirect_valid) begin
               state_d = S_WAIT_DROP;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Fetch PC and FIFO pointer next-state
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      if (accept) begin
         req_pc_d   = fetch_pc_q;
         fetch_pc_d = fetch_pc_q + STEP;
      end
      if (redirect_valid) fetch_pc_d = redirect_pc & ALIGN_MASK;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (redirect_valid) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !pop)      count_d = count_q + 1'b1;
         else if (pop && !push) count_d = count_q - 1'b1;
      end
   end

   // Outputs
   always_comb begin
      imem_req    = (state_q == S_REQ) || issue_resp;
      imem_addr   = fetch_pc_q;
      instr_valid = (count_q != '0);
      instr_data  = instr_valid ? mem_data_q[rd_ptr_q] : '0;
      instr_pc    = instr_valid ? mem_pc_q[rd_ptr_q]   : '0;
      dbg_state_o = state_q;
   end

   a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst) !(push && full));

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Testbench for rv32i_fetch_unit.
// Instance A uses the default parameters and runs against a responder with
// configurable grant stalls and response latency. The memory returns
// addr + 0x100. A reference model checks the delivered stream on every cycle.
// Instance B uses RESET_PC = 0xFFFF_FFF8 and covers PC wrap and reset
// asserted mid-operation.
module tb_rv32i_fetch_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- instance A ----------------
   logic        rst_a, fetch_en, redirect_valid, instr_ready;
   logic [31:0] redirect_pc;
   logic        imem_req, imem_gnt, imem_rvalid, instr_valid;
   logic [31:0] imem_addr, imem_rdata, instr_data, instr_pc;
   logic [1:0]  dbg_a;

   rv32i_fetch_unit u_dut_a (
      .clk(clk), .rst(rst_a), .fetch_en(fetch_en),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_data(instr_data), .instr_pc(instr_pc), .dbg_state_o(dbg_a)
   );

   // ---------------- instance B ----------------
   logic        b_rst, b_fetch_en, b_redir, b_ready;
   logic [31:0] b_redir_pc;
   logic        b_req, b_gnt, b_rvalid, b_valid;
   logic [31:0] b_addr, b_rdata, b_idata, b_ipc;
   logic [1:0]  b_dbg;

   rv32i_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_b (
      .clk(clk), .rst(b_rst), .fetch_en(b_fetch_en),
      .redirect_valid(b_redir), .redirect_pc(b_redir_pc),
      .imem_req(b_req), .imem_addr(b_addr), .imem_gnt(b_gnt),
      .imem_rvalid(b_rvalid), .imem_rdata(b_rdata),
      .instr_valid(b_valid), .instr_ready(b_ready),
      .instr_data(b_idata), .instr_pc(b_ipc), .dbg_state_o(b_dbg)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
      if (i < q.size()) return q[i];
      return 32'hBAD0_BAD0;
   endfunction

   // Main stimulus acts 2 time units after each rising edge.
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // ---------------- responder A ----------------
   // rvalid is decided at +1 and grant at +3, so the combinational request
   // (which depends on rvalid and on the stimulus at +2) settles before grant.
   logic        pend;
   int          pend_cnt;
   logic [31:0] pend_addr;
   int          lat       = 1;
   int          stall_cnt = 0;

   initial begin : resp_a
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      pend        = 1'b0;
      pend_cnt    = 0;
      pend_addr   = '0;
      forever begin
         @(posedge clk);
         #1;
         imem_rvalid = 1'b0;
         if (!rst_a) pend = 1'b0;
         else if (pend) begin
            pend_cnt--;
            if (pend_cnt <= 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = pend_addr + 32'h100;
               pend        = 1'b0;
            end
         end
         #2;
         imem_gnt = 1'b0;
         if (rst_a && imem_req) begin
            if (stall_cnt > 0) stall_cnt--;
            else begin
               imem_gnt  = 1'b1;
               pend      = 1'b1;
               pend_cnt  = lat;
               pend_addr = imem_addr;
            end
         end
      end
   end

   // ---------------- reference model and compare (A) ----------------
   // Stream model: granted addresses run sequentially from the last restart
   // point. Delivered instructions run sequentially from the same point with
   // data = pc + 0x100. A redirect restarts both at the aligned target.
   logic [31:0] exp_addr, exp_pc;
   logic        prev_stall, prev_redir, prev_hold_out;
   logic [31:0] prev_addr, prev_ipc, prev_idata;
   logic [31:0] grant_log[$], grant_cyc[$], pop_log[$], pop_data[$], pop_cyc[$];
   int          stall_cycles;

   always @(negedge clk) begin
      cyc++;
      if (!rst_a) begin
         exp_addr      = 32'h0;
         exp_pc        = 32'h0;
         prev_stall    = 1'b0;
         prev_redir    = 1'b0;
         prev_hold_out = 1'b0;
      end else begin
         if (prev_stall && !prev_redir) begin
            check32("req_hold", {31'b0, imem_req}, 32'h1);
            check32("addr_hold", imem_addr, prev_addr);
         end
         if (prev_redir) check32("flush_valid", {31'b0, instr_valid}, 32'h0);
         if (prev_hold_out && !prev_redir) begin
            check32("head_valid_hold", {31'b0, instr_valid}, 32'h1);
            check32("head_pc_hold", instr_pc, prev_ipc);
            check32("head_data_hold", instr_data, prev_idata);
         end
         if (imem_req && imem_gnt) begin
            check32("grant_addr", imem_addr, exp_addr);
            grant_log.push_back(imem_addr);
            grant_cyc.push_back(32'(cyc));
            exp_addr = exp_addr + 32'h4;
         end
         if (imem_req && !imem_gnt) stall_cycles++;
         if (instr_valid && instr_ready && !redirect_valid) begin
            check32("pop_pc", instr_pc, exp_pc);
            check32("pop_data", instr_data, exp_pc + 32'h100);
            pop_log.push_back(instr_pc);
            pop_data.push_back(instr_data);
            pop_cyc.push_back(32'(cyc));
            exp_pc = exp_pc + 32'h4;
         end
         prev_stall    = imem_req && !imem_gnt;
         prev_addr     = imem_addr;
         prev_hold_out = instr_valid && !instr_ready;
         prev_ipc      = instr_pc;
         prev_idata    = instr_data;
         prev_redir    = redirect_valid;
         if (redirect_valid) begin
            exp_addr = redirect_pc & 32'hFFFF_FFFC;
            exp_pc   = redirect_pc & 32'hFFFF_FFFC;
         end
      end
   end

   // ---------------- responder and pop log (B) ----------------
   logic        b_pend, b_stray;
   logic [31:0] b_pend_addr;
   logic [31:0] b_pop_pc[$], b_pop_data[$];

   initial begin : resp_b
      b_gnt       = 1'b0;
      b_rvalid    = 1'b0;
      b_rdata     = '0;
      b_pend      = 1'b0;
      b_pend_addr = '0;
      b_stray     = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         b_rvalid = 1'b0;
         if (!b_rst) b_pend = 1'b0;
         else if (b_stray) begin
            b_rvalid = 1'b1;
            b_rdata  = 32'hDEAD_BEEF;
            b_stray  = 1'b0;
         end else if (b_pend) begin
            b_rvalid = 1'b1;
            b_rdata  = b_pend_addr + 32'h100;
            b_pend   = 1'b0;
         end
         #2;
         b_gnt = 1'b0;
         if (b_rst && b_req) begin
            b_gnt       = 1'b1;
            b_pend      = 1'b1;
            b_pend_addr = b_addr;
         end
      end
   end

   always @(negedge clk) begin
      if (b_rst && b_valid && b_ready && !b_redir) begin
         b_pop_pc.push_back(b_ipc);
         b_pop_data.push_back(b_idata);
      end
   end

   task automatic clear_logs();
      grant_log.delete();
      grant_cyc.delete();
      pop_log.delete();
      pop_data.delete();
      pop_cyc.delete();
      stall_cycles = 0;
   endtask

   task automatic pulse_reset_a();
      rst_a          = 1'b0;
      redirect_valid = 1'b0;
      step(2);
      clear_logs();
      rst_a = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion, required finish within 100000 time units");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_a = 1'b0; fetch_en = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b1;
      b_rst = 1'b0; b_fetch_en = 1'b1; b_redir = 1'b0; b_redir_pc = '0; b_ready = 1'b1;
      stall_cycles = 0;
      step(2);

      // Reset values
      check32("rst_req", {31'b0, imem_req}, 32'h0);
      check32("rst_addr", imem_addr, 32'h0);
      check32("rst_valid", {31'b0, instr_valid}, 32'h0);
      check32("rst_data", instr_data, 32'h0);
      check32("rst_pc", instr_pc, 32'h0);
      check32("rst_b_addr", b_addr, 32'hFFFF_FFF8);

      // T1: streaming with 1-cycle memory
      clear_logs();
      rst_a = 1'b1;
      step(12);
      check32("t1_grant0", qget(grant_log, 0), 32'h0);
      check32("t1_grant1", qget(grant_log, 1), 32'h4);
      check32("t1_grant2", qget(grant_log, 2), 32'h8);
      check32("t1_pop0_pc", qget(pop_log, 0), 32'h0);
      check32("t1_pop0_data", qget(pop_data, 0), 32'h100);
      check32("t1_pop1_pc", qget(pop_log, 1), 32'h4);
      check32("t1_pop1_data", qget(pop_data, 1), 32'h104);
      check32("t1_latency", qget(pop_cyc, 0) - qget(grant_cyc, 0), 32'd2);
      check32("t1_back_to_back", qget(pop_cyc, 1) - qget(pop_cyc, 0), 32'd1);

      // T2: consumer stalled, FIFO fills to depth, then drains
      instr_ready = 1'b0;
      pulse_reset_a();
      step(20);
      check32("t2_grants", 32'(grant_log.size()), 32'd4);
      check32("t2_req_idle", {31'b0, imem_req}, 32'h0);
      check32("t2_valid", {31'b0, instr_valid}, 32'h1);
      check32("t2_head_pc", instr_pc, 32'h0);
      instr_ready = 1'b1;
      step(10);
      check32("t2_pop0", qget(pop_log, 0), 32'h0);
      check32("t2_pop1", qget(pop_log, 1), 32'h4);
      check32("t2_pop2", qget(pop_log, 2), 32'h8);
      check32("t2_pop3", qget(pop_log, 3), 32'hC);
      check32("t2_resume", qget(grant_log, 4), 32'h10);

      // T3: grant stalled 3 cycles, response 2 cycles after grant
      lat = 2; stall_cnt = 3;
      pulse_reset_a();
      for (int i = 0; i < 20; i++) begin
         if (grant_log.size() != 0) break;
         step(1);
      end
      fetch_en = 1'b0;
      step(8);
      check32("t3_stall_cycles", 32'(stall_cycles), 32'd3);
      check32("t3_grants", 32'(grant_log.size()), 32'd1);
      check32("t3_grant_addr", qget(grant_log, 0), 32'h0);
      check32("t3_pops", 32'(pop_log.size()), 32'd1);
      check32("t3_pop_pc", qget(pop_log, 0), 32'h0);
      check32("t3_pop_data", qget(pop_data, 0), 32'h100);
      fetch_en = 1'b1;

      // T4: redirect while waiting for the 0x8 response
      lat = 3; stall_cnt = 0;
      pulse_reset_a();
      for (int i = 0; i < 40; i++) begin
         if (pend && pend_addr == 32'h8) break;
         step(1);
      end
      check32("t4_wait_for_8", {31'b0, pend && pend_addr == 32'h8}, 32'h1);
      redirect_valid = 1'b1; redirect_pc = 32'h80;
      step(1);
      redirect_valid = 1'b0;
      step(20);
      check32("t4_pop0", qget(pop_log, 0), 32'h0);
      check32("t4_pop1", qget(pop_log, 1), 32'h80);
      check32("t4_pop2", qget(pop_log, 2), 32'h84);

      // T5: redirect coincident with a response, pop and two buffered entries
      lat = 1; instr_ready = 1'b0;
      pulse_reset_a();
      for (int i = 0; i < 20; i++) begin
         if (imem_rvalid && imem_rdata == 32'h108) break;
         step(1);
      end
      redirect_valid = 1'b1; redirect_pc = 32'h83; instr_ready = 1'b1;
      step(1);
      redirect_valid = 1'b0;
      step(10);
      check32("t5_grant_after", qget(grant_log, 3), 32'h80);
      check32("t5_pop0_pc", qget(pop_log, 0), 32'h80);
      check32("t5_pop0_data", qget(pop_data, 0), 32'h180);

      // T6: instance B, PC wrap from RESET_PC = 0xFFFF_FFF8
      b_rst = 1'b1;
      step(8);
      check32("t6_pc0", qget(b_pop_pc, 0), 32'hFFFF_FFF8);
      check32("t6_pc1", qget(b_pop_pc, 1), 32'hFFFF_FFFC);
      check32("t6_pc2", qget(b_pop_pc, 2), 32'h0);
      check32("t6_data0", qget(b_pop_data, 0), 32'h0000_00F8);
      check32("t6_data2", qget(b_pop_data, 2), 32'h100);

      // Reset asserted while a response returns; outputs drop at once
      for (int i = 0; i < 10; i++) begin
         if (b_rvalid) break;
         step(1);
      end
      b_rst = 1'b0;
      #1;
      check32("t6_arst_req", {31'b0, b_req}, 32'h0);
      check32("t6_arst_addr", b_addr, 32'hFFFF_FFF8);
      check32("t6_arst_valid", {31'b0, b_valid}, 32'h0);
      check32("t6_arst_data", b_idata, 32'h0);
      check32("t6_arst_pc", b_ipc, 32'h0);
      step(2);
      b_pop_pc.delete();
      b_pop_data.delete();
      b_rst   = 1'b1;
      b_stray = 1'b1;
      step(10);
      check32("t6_restart_pc0", qget(b_pop_pc, 0), 32'hFFFF_FFF8);
      check32("t6_restart_data0", qget(b_pop_data, 0), 32'h0000_00F8);
      check32("t6_restart_pc1", qget(b_pop_pc, 1), 32'hFFFF_FFFC);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
